instruction_loader: RTL and testbench
=====================================

// Module: instruction_loader
// PURPOSE
//  Boot-time controller for the instruction memory write port. Receives a program as a byte stream from the UART receiver.
//  Assembles big-endian 32-bit words and writes them at consecutive addresses from 0 through write_enable/write_address/write_data.
//  Holds the CPU in reset until loading completes; afterwards the write port is idle and the CPU owns the memory read side.
// PARAMETERS
//  MEM_SIZE   20000  instruction words available; word count above this is rejected
//  ADDR_W     16     width of write address and word counter
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  rst_n        in   1   asynchronous active-low reset
//  reload       in   1   1-cycle pulse: abort any load, restart in RECV_COUNT
//  rx_valid     in   1   1-cycle strobe: rx_data holds a received byte
//  rx_data      in   8   received byte
//  imem_we      out  1   write strobe to instruction memory (write_enable)
//  imem_waddr   out  16  word address (write_address)
//  imem_wdata   out  32  word data (write_data)
//  cpu_hold     out  1   1 = keep CPU core in reset
//  load_done    out  1   1 = program loaded successfully (sticky until reload/reset)
//  load_error   out  1   1 = load rejected (sticky until reload/reset)
//  words_loaded out  16  number of words written so far
// BEHAVIOUR
//  Reset values: imem_we=0, imem_waddr=0, imem_wdata=0, cpu_hold=1, load_done=0, load_error=0, words_loaded=0; state=RECV_COUNT.
//  States: RECV_COUNT -> RECV_WORD -> (RECV_SUM) -> DONE; any -> ERROR on violation; reload from any state -> RECV_COUNT.
//  RECV_COUNT: 4 bytes big-endian (first byte = bits 31:24) form word count N.
//   - N==0 -> DONE on the cycle after the 4th byte.
//   - N>MEM_SIZE or bits 31:16 nonzero -> ERROR.
//   - otherwise -> RECV_WORD.
//  RECV_WORD: byte index 0..3 shifts into assembly register, first byte -> bits 31:24.
//   - On 4th byte: next cycle imem_we=1 for exactly 1 cycle with imem_waddr=words_loaded, imem_wdata=assembled word; words_loaded increments the same cycle.
//   - Write latency: 1 cycle after the 4th rx_valid.
//   - The next byte is accepted in that same cycle (rx_valid every cycle is legal; no backpressure, no byte dropped).
//   - After the N-th write issues -> DONE (or RECV_SUM if CHECKSUM_EN).
//  DONE: cpu_hold=0, load_done=1, imem_we=0; further rx bytes ignored.
//  ERROR: cpu_hold=1, load_error=1, no writes; rx ignored until reload.
//  reload together with rx_valid in the same cycle: reload wins, byte discarded, counters cleared.
//  Reset mid-word: partial word discarded, nothing written.
//  Words already written to memory are not erased by reload/reset.
//  imem_waddr never exceeds MEM_SIZE-1 (guaranteed by the count check).
// CONFIGURATION
//  INSTRUCTION_LOADER_CHECKSUM_EN defined:
//   - After N words, state RECV_SUM takes 1 byte = XOR of all word bytes (count bytes excluded).
//   - Match -> DONE; mismatch -> ERROR.
//   - N==0 still requires the checksum byte (expected 8'h00).
//  Undefined: no RECV_SUM state; DONE directly after the N-th write.
// STRUCTURE
//  Shared package/header instr_pkg: state encoding localparams
//  (ST_RECV_COUNT, ST_RECV_WORD, ST_RECV_SUM, ST_DONE, ST_ERROR), IMEM_ADDR_W=16, IMEM_DATA_W=32.
//  One natural sub-module: byte_to_word_assembler (byte index counter + shift register, word_valid pulse), reused for count and words.
//  Controller FSM, address counter and checksum stay in instruction_loader.
// TESTING
//  1. Bytes 00 00 00 02, DE AD BE EF, 01 23 45 67 -> writes @0=DEADBEEF, @1=01234567; load_done=1, cpu_hold=0, words_loaded=2.
//  2. Count 00 00 00 00 -> no imem_we; load_done=1 one cycle after 4th byte.
//  3. Count 00 00 4E 21 (20001) -> load_error=1, cpu_hold=1, no writes; later reload + valid 1-word stream -> load_done=1.
//  4. rx_valid held 1 for all 12 bytes of case 1 back-to-back -> same two writes, each 1 cycle after its 4th byte, none lost.
//  5. rst_n low after 2 bytes of word 1 in case 1, then full stream resent -> exactly 2 writes, addresses restart at 0.
//  6. CHECKSUM_EN: case 1 + byte 8'h?? = XOR of the 8 word bytes -> DONE; same stream with wrong byte -> load_error=1.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and memory port widths.
package instr_pkg;

  localparam int IMEM_ADDR_W = 16;
  localparam int IMEM_DATA_W = 32;

  localparam logic [2:0] ST_RECV_COUNT = 3'd0;
  localparam logic [2:0] ST_RECV_WORD  = 3'd1;
  localparam logic [2:0] ST_RECV_SUM   = 3'd2;
  localparam logic [2:0] ST_DONE       = 3'd3;
  localparam logic [2:0] ST_ERROR      = 3'd4;

endpackage

// File: rtl/byte_to_word_assembler.sv
// byte_to_word_assembler: packs 4 bytes big-endian (first byte -> bits 31:24) into a word.
// Latency: word_vld is combinational, asserted together with the 4th byte_vld.
// Backpressure: none; a byte is accepted on every byte_vld, clear drops a partial word.
module byte_to_word_assembler
  import instr_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   byte_vld,
  input  logic [7:0]             byte_dat,
  output logic                   word_vld,
  output logic [IMEM_DATA_W-1:0] word_dat
);

  logic [1:0]  idx;
  logic [23:0] shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= 2'd0;
      shift <= 24'd0;
    end else if (clear) begin
      idx   <= 2'd0;
    end else if (byte_vld) begin
      idx   <= idx + 2'd1;
      shift <= {shift[15:0], byte_dat};
    end
  end

  // The 4th byte bypasses the shift register so the word is ready in its own cycle.
  assign word_vld = byte_vld && !clear && (idx == 2'd3);
  assign word_dat = {shift, byte_dat};

endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: boots instruction memory from a UART byte stream; holds the CPU in reset until done.
// Latency: each word is written 1 cycle after its 4th byte; optional checksum byte with INSTRUCTION_LOADER_CHECKSUM_EN.
// Backpressure: none; one byte per cycle accepted, bytes in DONE/ERROR (or with reload) are dropped.
module instruction_loader
  import instr_pkg::*;
#(
  parameter int MEM_SIZE = 20000,
  parameter int ADDR_W   = IMEM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   reload,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   imem_we,
  output logic [ADDR_W-1:0]      imem_waddr,
  output logic [IMEM_DATA_W-1:0] imem_wdata,
  output logic                   cpu_hold,
  output logic                   load_done,
  output logic                   load_error,
  output logic [ADDR_W-1:0]      words_loaded
);

  logic [2:0]             state;
  logic [ADDR_W-1:0]      count;
  logic [ADDR_W-1:0]      words_next;
  logic                   asm_vld;
  logic                   word_vld;
  logic [IMEM_DATA_W-1:0] word_dat;
  logic                   count_bad;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [7:0]             sum;
`endif

  // Only the count and word phases feed the assembler; everything else is dropped here.
  assign asm_vld = rx_valid && !reload &&
                   ((state == ST_RECV_COUNT) || (state == ST_RECV_WORD));

  byte_to_word_assembler u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (reload),
    .byte_vld (asm_vld),
    .byte_dat (rx_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  assign words_next = words_loaded + ADDR_W'(1);
  assign count_bad  = (word_dat[IMEM_DATA_W-1:ADDR_W] != '0) ||
                      (word_dat > IMEM_DATA_W'(MEM_SIZE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RECV_COUNT;
      count        <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      sum          <= 8'd0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (reload) begin
        state        <= ST_RECV_COUNT;
        count        <= '0;
        words_loaded <= '0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        sum          <= 8'd0;
`endif
      end else begin
        case (state)
          ST_RECV_COUNT: begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            sum <= 8'd0;
`endif
            if (word_vld) begin
              if (count_bad) begin
                state <= ST_ERROR;
              end else if (word_dat == '0) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                state <= ST_RECV_SUM;
`else
                state <= ST_DONE;
`endif
              end else begin
                count <= word_dat[ADDR_W-1:0];
                state <= ST_RECV_WORD;
              end
            end
          end
          ST_RECV_WORD: begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            if (rx_valid) sum <= sum ^ rx_data;
`endif
            if (word_vld) begin
              imem_we      <= 1'b1;
              imem_waddr   <= words_loaded;
              imem_wdata   <= word_dat;
              words_loaded <= words_next;
              if (words_next == count) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                state <= ST_RECV_SUM;
`else
                state <= ST_DONE;
`endif
              end
            end
          end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
          ST_RECV_SUM: begin
            if (rx_valid) state <= (rx_data == sum) ? ST_DONE : ST_ERROR;
          end
`endif
          default: state <= state;
        endcase
      end
    end
  end

  assign cpu_hold   = (state != ST_DONE);
  assign load_done  = (state == ST_DONE);
  assign load_error = (state == ST_ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: expected writes are queued as words are sent and checked on imem_we.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reload = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        imem_we;
  logic [15:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;

  instruction_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reload       (reload),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         sb[$];
  wr_t         mon_e;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          nwr = 0;
  int          nwr_start;
  logic [15:0] exp_addr = 16'd0;
  logic [31:0] prog [2] = '{32'hDEADBEEF, 32'h01234567};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every write must match the oldest queued word, including its issue cycle.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      nwr++;
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("waddr", 64'(imem_waddr), 64'(mon_e.addr));
        chk("wdata", 64'(imem_wdata), 64'(mon_e.data));
        chk("wr_latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input bit expect_wr);
    wr_t e;
    for (int i = 0; i < 3; i++) send_byte(w[31-8*i -: 8], gap);
    rx_valid = 1'b1;
    rx_data  = w[7:0];
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (expect_wr) begin
      e.addr = exp_addr;
      e.data = w;
      e.cyc  = cyc;
      sb.push_back(e);
      exp_addr++;
    end
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_prog(input int nw, input int gap, input logic [7:0] sum_flip);
    logic [7:0] sum;
    sum = 8'd0;
    send_word(32'(nw), gap, 1'b0);
    for (int i = 0; i < nw; i++) begin
      send_word(prog[i], gap, 1'b1);
      sum = sum ^ prog[i][31:24] ^ prog[i][23:16] ^ prog[i][15:8] ^ prog[i][7:0];
    end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    send_byte(sum ^ sum_flip, gap);
`else
    if (sum_flip != 8'd0) sum = sum ^ sum_flip;
`endif
  endtask

  task automatic do_reload(input bit with_byte);
    reload   = 1'b1;
    rx_valid = with_byte;
    rx_data  = 8'hFF;
    @(posedge clk); #1;
    reload   = 1'b0;
    rx_valid = 1'b0;
    exp_addr = 16'd0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    reload   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_addr = 16'd0;
    @(posedge clk); #1;
  endtask

  task automatic settle_and_check(input string tag, input bit done, input bit err, input int words, input int writes);
    repeat (3) begin @(posedge clk); #1; end
    chk({tag, "_done"}, 64'(load_done), 64'(done));
    chk({tag, "_err"}, 64'(load_error), 64'(err));
    chk({tag, "_hold"}, 64'(cpu_hold), 64'(!done));
    chk({tag, "_words"}, 64'(words_loaded), 64'(words));
    chk({tag, "_nwr"}, 64'(nwr - nwr_start), 64'(writes));
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    do_reset();
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_waddr", 64'(imem_waddr), 64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_hold", 64'(cpu_hold), 64'd1);
    chk("rst_done", 64'(load_done), 64'd0);
    chk("rst_err", 64'(load_error), 64'd0);
    chk("rst_words", 64'(words_loaded), 64'd0);

    // 1: two words with idle gaps; trailing bytes in DONE must be ignored
    nwr_start = nwr;
    send_prog(2, 2, 8'd0);
    for (int i = 0; i < 4; i++) send_byte(8'h11, 0);
    settle_and_check("t1", 1'b1, 1'b0, 2, 2);

    // 2: empty program, reload carrying a byte that must be discarded
    do_reload(1'b1);
    chk("t2_reload_hold", 64'(cpu_hold), 64'd1);
    chk("t2_reload_words", 64'(words_loaded), 64'd0);
    nwr_start = nwr;
    for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
    chk("t2_not_yet", 64'(load_done), 64'd0);
    send_byte(8'h00, 0);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    chk("t2_wait_sum", 64'(load_done), 64'd0);
    send_byte(8'h00, 0);
`endif
    chk("t2_done_next", 64'(load_done), 64'd1);
    settle_and_check("t2", 1'b1, 1'b0, 0, 0);

    // 3: count 20001 rejected, bytes ignored in ERROR, then a valid 1-word load
    do_reload(1'b0);
    nwr_start = nwr;
    send_word(32'h00004E21, 0, 1'b0);
    send_word(32'hCAFEF00D, 0, 1'b0);
    settle_and_check("t3_err", 1'b0, 1'b1, 0, 0);
    do_reload(1'b0);
    send_word(32'h00010000, 1, 1'b0);
    settle_and_check("t3_upper", 1'b0, 1'b1, 0, 0);
    do_reload(1'b0);
    send_prog(1, 1, 8'd0);
    settle_and_check("t3_ok", 1'b1, 1'b0, 1, 1);

    // 4: all bytes back-to-back
    do_reload(1'b0);
    nwr_start = nwr;
    send_prog(2, 0, 8'd0);
    settle_and_check("t4", 1'b1, 1'b0, 2, 2);

    // 5: reset mid-word discards the partial word, then full stream resent
    do_reload(1'b0);
    nwr_start = nwr;
    send_word(32'd2, 0, 1'b0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    do_reset();
    chk("t5_rst_words", 64'(words_loaded), 64'd0);
    chk("t5_rst_hold", 64'(cpu_hold), 64'd1);
    send_prog(2, 1, 8'd0);
    settle_and_check("t5", 1'b1, 1'b0, 2, 2);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    // 6: corrupted checksum byte; words are still written but the load is rejected
    do_reload(1'b0);
    nwr_start = nwr;
    send_prog(2, 0, 8'h01);
    settle_and_check("t6_bad_sum", 1'b0, 1'b1, 2, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
